// File: rtl/div_sequencer.sv
// div_sequencer: request front-end for the 4-bit restoring divider.
// It queues divide requests in a small FIFO and issues them one at a time.
// Operands stay stable in the op registers for the whole operation.
// Results land in a response register with valid/ready backpressure.
// Divide-by-zero requests are answered locally and never reach the divider.
module div_sequencer #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_dividend,
    input  logic [3:0]       req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_go,
    output logic [3:0]       div_dividend,
    output logic [3:0]       div_divisor,
    input  logic [3:0]       div_quotient,
    input  logic [3:0]       div_remainder,
    input  logic             div_result_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_quotient,
    output logic [3:0]       rsp_remainder,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_dbz
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]       dividend;
        logic [3:0]       divisor;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    req_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    req_t          head;
    req_t          op;
    state_t        state;
    logic          slot_free;

    // The extra pointer bit tells full from empty when the index bits match.
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready    = !fifo_full;
    assign push         = req_valid && !fifo_full;
    assign head         = mem[rd_ptr[AW-1:0]];
    assign slot_free    = !rsp_valid || rsp_ready;
    assign div_dividend = op.dividend;
    assign div_divisor  = op.divisor;

    // Pop decision: a nonzero-divisor head always pops; a zero-divisor head needs a free slot.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned and infers a latch.
        pop = 1'b0;
        if (state == IDLE && !fifo_empty) begin
            if (head.divisor != 4'd0) begin
                pop = 1'b1;
            end else if (slot_free) begin
                pop = 1'b1;
            end
        end
    end

    // FIFO storage writes on accepted pushes.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the pointers alone decide which entries are valid.
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{dividend: req_dividend, divisor: req_divisor, tag: req_tag};
        end
    end

    // FIFO pointers advance on push and pop and wrap naturally.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Issue FSM with registered Go, op registers and response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            div_go        <= 1'b0;
            op            <= '0;
            rsp_valid     <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_tag       <= '0;
            rsp_dbz       <= 1'b0;
        end else begin
            div_go <= 1'b0;
            // A consumed response drops; a load in the same cycle overrides this below.
            if (rsp_ready) rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head.divisor != 4'd0) begin
                            op     <= head;
                            div_go <= 1'b1;
                            state  <= ISSUE;
                        end else begin
                            rsp_valid     <= 1'b1;
                            rsp_quotient  <= 4'hF;
                            rsp_remainder <= head.dividend;
                            rsp_tag       <= head.tag;
                            rsp_dbz       <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // ResultValid holds until the next Go, so a stall here loses nothing.
                    if (div_result_valid && slot_free) begin
                        rsp_valid     <= 1'b1;
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_tag       <= op.tag;
                        rsp_dbz       <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer.
// A behavioural divider answers Go, and a scoreboard queue holds expected responses.
// A negedge monitor compares every response handshake against the queue.
module tb_div_sequencer;

    localparam int DEPTH = 2;
    localparam int TAG_W = 2;

    typedef struct packed {
        logic [3:0]       q;
        logic [3:0]       r;
        logic [TAG_W-1:0] tag;
        logic             dbz;
    } rsp_t;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_dividend;
    logic [3:0]       req_divisor;
    logic [TAG_W-1:0] req_tag;
    logic             div_go;
    logic [3:0]       div_dividend;
    logic [3:0]       div_divisor;
    logic [3:0]       div_quotient;
    logic [3:0]       div_remainder;
    logic             div_result_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_quotient;
    logic [3:0]       rsp_remainder;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_dbz;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rise_cyc = -1;
    int   last_go_cyc = -1;
    int   go_count = 0;
    int   dv_phase = 0;
    logic [3:0] dv_a, dv_b;
    rsp_t sb[$];

    div_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
        .div_go(div_go), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_result_valid(div_result_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: operands taken the cycle after Go, result valid 6 cycles after Go.
    always @(posedge clk) begin
        if (reset) begin
            dv_phase         <= 0;
            div_result_valid <= 1'b0;
            div_quotient     <= 4'd0;
            div_remainder    <= 4'd0;
        end else if (dv_phase == 0) begin
            if (div_go) begin
                dv_phase         <= 1;
                div_result_valid <= 1'b0;
            end
        end else begin
            if (dv_phase == 1) begin
                dv_a <= div_dividend;
                dv_b <= div_divisor;
            end
            if (dv_phase == 5) begin
                div_result_valid <= 1'b1;
                div_quotient     <= (dv_b == 4'd0) ? 4'hF : dv_a / dv_b;
                div_remainder    <= (dv_b == 4'd0) ? dv_a : dv_a % dv_b;
                dv_phase         <= 0;
            end else begin
                dv_phase <= dv_phase + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rsp_t model(input logic [3:0] a, input logic [3:0] b, input logic [TAG_W-1:0] t);
        rsp_t e;
        if (b == 4'd0) e = '{q: 4'hF, r: a, tag: t, dbz: 1'b1};
        else           e = '{q: a / b, r: a % b, tag: t, dbz: 1'b0};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one request for one cycle; the expected response is queued only if accepted.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [TAG_W-1:0] t, output bit acc);
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        req_tag      = t;
        @(negedge clk);
        acc = req_ready;
        step();
        acc_cyc = cyc;
        if (acc) sb.push_back(model(a, b, t));
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        req_valid = 1'b0;
        while ((sb.size() != 0 || rsp_valid) && n < budget) begin
            step();
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // Response monitor and Go checker.
    initial begin
        logic  prev_go = 1'b0;
        logic  prev_valid = 1'b0;
        logic  prev_hold = 1'b0;
        rsp_t  held;
        rsp_t  got;
        rsp_t  exp;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_go = 1'b0;
                prev_valid = 1'b0;
                prev_hold = 1'b0;
                continue;
            end
            got = '{q: rsp_quotient, r: rsp_remainder, tag: rsp_tag, dbz: rsp_dbz};
            if (div_go) begin
                go_count++;
                last_go_cyc = cyc;
                check("go_pulse_rules", {30'd0, prev_go, (dv_phase != 0)}, 32'd0);
            end
            if (prev_hold) check("rsp_held_stable", {rsp_valid, got}, {1'b1, held});
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {1'b1, got}, 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("rsp_data", got, exp);
                end
            end
            prev_hold  = rsp_valid && !rsp_ready;
            held       = got;
            prev_valid = rsp_valid;
            prev_go    = div_go;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bit acc;
        int a0;
        int g0;
        bit exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
        req_tag = '0; rsp_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_div_go", div_go, 0);
        check("reset_data", {rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz, div_dividend, div_divisor}, 0);
        step();

        // 13/4: single Go one cycle after accept, response 8 cycles after accept.
        g0 = go_count;
        send(4'd13, 4'd4, 2'd1, acc);
        a0 = acc_cyc;
        check("t1_accept", acc, 1);
        drain("t1_drain", 40);
        check("t1_latency", rise_cyc - a0, 8);
        check("t1_go_cycle", last_go_cyc - a0, 1);
        check("t1_go_count", go_count - g0, 1);

        // 7/0 answered locally one cycle after accept, no Go.
        step();
        g0 = go_count;
        send(4'd7, 4'd0, 2'd2, acc);
        a0 = acc_cyc;
        drain("t2_drain", 20);
        check("t2_latency", rise_cyc - a0, 1);
        check("t2_no_go", go_count - g0, 0);

        // Backpressure: first response held, second op parked in WAIT with ResultValid high.
        step();
        rsp_ready = 1'b0;
        g0 = go_count;
        send(4'd15, 4'd2, 2'd0, acc);
        send(4'd9, 4'd3, 2'd1, acc);
        req_valid = 1'b0;
        repeat (30) step();
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_first_q_r", {rsp_quotient, rsp_remainder, rsp_tag}, {4'd7, 4'd1, 2'd0});
        check("t3_div_rv_high", div_result_valid, 1);
        check("t3_go_count", go_count - g0, 2);
        rsp_ready = 1'b1;
        drain("t3_drain", 40);

        // Fill: DEPTH+1 requests fit (FIFO plus op registers), later pushes drop.
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), 2'(i), acc);
            check("t4_req_ready", acc, exp_rdy[i]);
        end
        req_valid = 1'b0;
        repeat (20) step();
        rsp_ready = 1'b1;
        drain("t4_drain", 200);

        // Mixed stream.
        step();
        send(4'd10, 4'd0, 2'd0, acc);
        send(4'd10, 4'd3, 2'd1, acc);
        send(4'd0, 4'd5, 2'd2, acc);
        drain("t5_drain", 100);

        // Reset during WAIT discards the in-flight op.
        step();
        send(4'd14, 4'd5, 2'd3, acc);
        req_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        check("t6_reset_ready_valid_go", {req_ready, rsp_valid, div_go}, 3'b100);
        check("t6_reset_data", {rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz, div_dividend, div_divisor}, 0);
        step();
        reset = 1'b0;
        step();
        send(4'd14, 4'd5, 2'd1, acc);
        a0 = acc_cyc;
        drain("t6_drain", 40);
        check("t6_latency", rise_cyc - a0, 8);
        repeat (10) step();

        // Random traffic with random backpressure.
        for (int i = 0; i < 120; i++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                send(4'($urandom_range(0, 15)),
                     ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                     2'($urandom_range(0, 3)), acc);
            end else begin
                req_valid = 1'b0;
                step();
            end
        end
        rsp_ready = 1'b1;
        drain("rand_drain", 400);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
